// File: rtl/serial_adder_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : serial_adder_arbiter
//  Purpose  : Two round-robin requesters share one 1-bit full-adder cell that
//             adds N-bit operands LSB first over N cycles.
//  Revision : 1.0
// ============================================================================
module serial_adder_arbiter #(
  parameter int N  = 5,
  parameter int CW = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [N-1:0] req0_a,
  input  logic [N-1:0] req0_b,
  input  logic         req0_cin,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [N-1:0] req1_a,
  input  logic [N-1:0] req1_b,
  input  logic         req1_cin,
  output logic         res_valid,
  input  logic         res_ready,
  output logic [N-1:0] res_sum,
  output logic         res_cout,
  output logic         res_id,
  output logic         busy
);

  localparam logic [1:0] C_IDLE = 2'd0;
  localparam logic [1:0] C_ADD  = 2'd1;
  localparam logic [1:0] C_DONE = 2'd2;

  logic [1:0]    state_q, state_d;
  logic          rr_q, rr_d;
  logic          owner_q, owner_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          carry_q, carry_d;
  logic [N-1:0]  a_q, a_d, b_q, b_d, s_q, s_d;
  logic [N-1:0]  res_sum_q, res_sum_d;
  logic          res_cout_q, res_cout_d;
  logic          res_id_q, res_id_d;

  logic w_any, w_grant, w_xfer, w_sum, w_cout;

  // Contention goes to rr_q; a lone requester always wins.
  assign w_any   = req0_valid | req1_valid;
  assign w_grant = (req0_valid && req1_valid) ? rr_q : req1_valid;
  assign w_xfer  = (state_q == C_IDLE) && w_any && !rst;

  assign w_sum  = a_q[0] ^ b_q[0] ^ carry_q;
  assign w_cout = (a_q[0] & b_q[0]) | (carry_q & (a_q[0] ^ b_q[0]));

  assign req0_ready = w_xfer && !w_grant;
  assign req1_ready = w_xfer && w_grant;
  assign res_valid  = (state_q == C_DONE);
  assign busy       = (state_q == C_ADD) || (state_q == C_DONE);
  assign res_sum    = res_sum_q;
  assign res_cout   = res_cout_q;
  assign res_id     = res_id_q;

  always_comb begin
    state_d    = state_q;
    rr_d       = rr_q;
    owner_d    = owner_q;
    cnt_d      = cnt_q;
    carry_d    = carry_q;
    a_d        = a_q;
    b_d        = b_q;
    s_d        = s_q;
    res_sum_d  = res_sum_q;
    res_cout_d = res_cout_q;
    res_id_d   = res_id_q;
    case (state_q)
      C_IDLE: begin
        if (w_xfer) begin
          a_d     = w_grant ? req1_a   : req0_a;
          b_d     = w_grant ? req1_b   : req0_b;
          carry_d = w_grant ? req1_cin : req0_cin;
          owner_d = w_grant;
          cnt_d   = '0;
          rr_d    = ~w_grant;
          state_d = C_ADD;
        end
      end
      C_ADD: begin
        a_d     = a_q >> 1;
        b_d     = b_q >> 1;
        s_d     = {w_sum, s_q[N-1:1]};
        carry_d = w_cout;
        cnt_d   = cnt_q + CW'(1);
        // Publish the result registers on the final shift so DONE sees them.
        if (cnt_q == CW'(N - 1)) begin
          state_d    = C_DONE;
          res_cout_d = w_cout;
          res_sum_d  = {w_sum, s_q[N-1:1]};
          res_id_d   = owner_q;
        end
      end
      C_DONE: begin
        if (res_ready) state_d = C_IDLE;
      end
      default: state_d = C_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= C_IDLE;
      rr_q       <= 1'b0;
      owner_q    <= 1'b0;
      cnt_q      <= '0;
      carry_q    <= 1'b0;
      a_q        <= '0;
      b_q        <= '0;
      s_q        <= '0;
      res_sum_q  <= '0;
      res_cout_q <= 1'b0;
      res_id_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      rr_q       <= rr_d;
      owner_q    <= owner_d;
      cnt_q      <= cnt_d;
      carry_q    <= carry_d;
      a_q        <= a_d;
      b_q        <= b_d;
      s_q        <= s_d;
      res_sum_q  <= res_sum_d;
      res_cout_q <= res_cout_d;
      res_id_q   <= res_id_d;
    end
  end

endmodule
`default_nettype wire
